bus_sequencer: RTL and testbench
================================

Name: bus_sequencer

Overview:
- Upstream stage of the address decoder. Time-multiplexes the shared 17-bit system bus between the MCU SPI bridge and the 6502 CPU.
- Generates the CPU phi2 clock.
- Drives bus_addr/bus_rw_b into the decoder and consumes its registered ram_enable/write_enable to time the SRAM strobes.
- Each CPU cycle is two fixed slots: SPI slot first, then CPU slot.

Parameters:
- SLOT_BITS, 4, log2 of clk cycles per slot; 16 clocks per slot, 32 per CPU cycle; legal range >= 3.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- spi_addr  in  17  SPI bridge request address
- spi_wr_data  in  8  SPI write data
- spi_rw_b  in  1  1 = read, 0 = write
- spi_valid  in  1  request valid
- spi_ready  out  1  request slot free; accept = spi_valid & spi_ready
- spi_done  out  1  one-clk pulse when the accepted request completes
- spi_rd_data  out  8  captured read data, valid from spi_done onward
- cpu_addr  in  16  CPU address bus
- cpu_rw_b  in  1  CPU R/W
- clk_cpu  out  1  phi2 to the CPU
- bus_addr  out  17  to the decoder
- bus_rw_b  out  1  to the decoder; 0 = write
- spi_data_oe  out  1  drive spi_wr_data onto the data bus
- ram_enable  in  1  from the decoder, 1-clk registered latency
- write_enable  in  1  from the decoder, write permitted
- ram_data_in  in  8  SRAM data bus sample
- ram_oe_b  out  1  SRAM output enable, active low
- ram_we_b  out  1  SRAM write enable, active low

Behaviour:
- Counter count[SLOT_BITS:0] free-runs and wraps. slot = MSB (0 = SPI, 1 = CPU). p = low SLOT_BITS bits; N = 2^SLOT_BITS.
- Reset values:
  - count = 0, clk_cpu = 0
  - bus_addr = 0, bus_rw_b = 1
  - ram_oe_b = 1, ram_we_b = 1, spi_data_oe = 0
  - spi_ready = 1, spi_done = 0, spi_rd_data = 0
  - pending request cleared
- clk_cpu is registered: 1 exactly while slot = 1. Rising edge coincides with CPU-slot p = 0.
- Request latch:
  - On accept, latch addr/data/rw and deassert spi_ready the next clk.
  - An accept on the same clk as SPI-slot p = 0 is not serviced in that slot; it waits for the next SPI slot.
- Slot start (p = 0):
  - SPI slot with pending request: bus_addr <= spi_addr, bus_rw_b <= spi_rw_b; slot marked active.
  - SPI slot with nothing pending: slot is idle. bus_addr/bus_rw_b hold their values and no strobes are issued.
  - CPU slot: bus_addr <= {1'b0, cpu_addr}, bus_rw_b <= cpu_rw_b. The CPU slot is always active.
- p = 1: decoder outputs become valid; the block ignores them before p = 2.
- Strobe window, registered outputs, asserted for p in [2, N-3] of an active slot:
  - ram_oe_b = 0 iff ram_enable & bus_rw_b.
  - ram_we_b = 0 iff ram_enable & write_enable & ~bus_rw_b.
  - spi_data_oe = 1 for an active SPI write slot across [1, N-2], so data covers ram_we_b with one clk of setup and hold.
- p = N-4, active SPI read: spi_rd_data <= ram_data_in.
- p = N-2: all strobes deasserted.
- p = N-1, active SPI slot: spi_done = 1 for one clk, pending cleared, spi_ready = 1 at the next clk.
- IO addresses (ram_enable = 0) still complete normally: no SRAM strobe, spi_done still pulses, spi_rd_data captures the bus.
- A write to a read-only region (write_enable = 0) produces no ram_we_b and still completes.
- spi_valid is ignored while spi_ready = 0.
- Reset mid-slot takes effect the next clk:
  - strobes deasserted immediately
  - any pending request dropped with no spi_done
  - counter restarts at SPI-slot p = 0

Decomposition:
- Shared constants file bus_timing_pkg: SLOT_BITS default, strobe start/end offsets (2, N-3), capture offset (N-4), done offset (N-1), decoder latency (1). The decoder and the future video fetch logic use the same file.
- One natural sub-module, phase_counter: slot/phase counter with reset and decoded phase-match strobes.

Test Plan:
1. Reset, then 64 clks free-run -> clk_cpu toggles with period 32 clks (high 16, low 16); ram_oe_b/ram_we_b stay 1 throughout the SPI slots since nothing is pending.
2. CPU read: cpu_addr = $8000, cpu_rw_b = 1, ram_enable = 1 -> bus_addr = 0x08000 at CPU p = 0; ram_oe_b low for CPU p = 2..13; ram_we_b stays 1.
3. SPI write of $A5 to 0x00100, write_enable = 1 -> ram_we_b low for SPI p = 2..13; spi_data_oe high for p = 1..14; spi_done pulses at p = 15; spi_ready high at the next clk.
4. SPI read of 0x0E810 (ram_enable = 0), bus driven $3C -> no ram_oe_b; spi_rd_data = $3C at spi_done.
5. spi_valid asserted exactly at SPI-slot p = 0 -> request is not serviced that slot; spi_done arrives 47 clks later, at p = 15 of the next SPI slot.
6. Reset asserted at SPI-slot p = 6 during an active write -> ram_we_b = 1 the next clk, no spi_done, spi_ready = 1; counter restarts at 0.

Source files
------------

// File: rtl/bus_timing_pkg.sv
// ============================================================================
// Module      : bus_timing_pkg
// Description : Shared slot/phase timing constants for the system bus
//               sequencer, address decoder and video fetch logic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bus_timing_pkg;

    localparam int c_slot_bits_def = 4;
    localparam int c_dec_latency   = 1;
    localparam int c_strobe_start  = 2;

    typedef enum logic {
        SLOT_SPI = 1'b0,
        SLOT_CPU = 1'b1
    } slot_e;

    function automatic int f_strobe_end(input int slot_bits);
        return (1 << slot_bits) - 3;
    endfunction

    function automatic int f_capture(input int slot_bits);
        return (1 << slot_bits) - 4;
    endfunction

    function automatic int f_done(input int slot_bits);
        return (1 << slot_bits) - 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/phase_counter.sv
// ============================================================================
// Module      : phase_counter
// Description : Free-running slot/phase counter with decoded phase strobes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module phase_counter
    import bus_timing_pkg::*;
#(
    parameter int SLOT_BITS = c_slot_bits_def
) (
    input  logic  clk,
    input  logic  reset,
    output slot_e o_slot,
    output slot_e o_nxt_slot,
    output logic  o_nxt_start,
    output logic  o_nxt_strobe,
    output logic  o_nxt_data,
    output logic  o_nxt_done,
    output logic  o_capture
);

    localparam logic [SLOT_BITS-1:0] c_p_start   = '0;
    localparam logic [SLOT_BITS-1:0] c_p_strb_lo = SLOT_BITS'(c_strobe_start);
    localparam logic [SLOT_BITS-1:0] c_p_strb_hi = SLOT_BITS'(f_strobe_end(SLOT_BITS));
    // Data drive brackets the write strobe by one clock on each side.
    localparam logic [SLOT_BITS-1:0] c_p_data_lo = SLOT_BITS'(c_strobe_start - 1);
    localparam logic [SLOT_BITS-1:0] c_p_data_hi = SLOT_BITS'(f_strobe_end(SLOT_BITS) + 1);
    localparam logic [SLOT_BITS-1:0] c_p_cap     = SLOT_BITS'(f_capture(SLOT_BITS));
    localparam logic [SLOT_BITS-1:0] c_p_done    = SLOT_BITS'(f_done(SLOT_BITS));

    logic [SLOT_BITS:0]   r_count;
    logic [SLOT_BITS:0]   w_count_nxt;
    logic [SLOT_BITS-1:0] w_p;
    logic [SLOT_BITS-1:0] w_p_nxt;

    assign w_count_nxt = r_count + (SLOT_BITS+1)'(1);
    assign w_p         = r_count[SLOT_BITS-1:0];
    assign w_p_nxt     = w_count_nxt[SLOT_BITS-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_nxt;
        end
    end

    // Strobes decode the phase being entered so consumers can register on it.
    assign o_slot       = slot_e'(r_count[SLOT_BITS]);
    assign o_nxt_slot   = slot_e'(w_count_nxt[SLOT_BITS]);
    assign o_nxt_start  = (w_p_nxt == c_p_start);
    assign o_nxt_strobe = (w_p_nxt >= c_p_strb_lo) && (w_p_nxt <= c_p_strb_hi);
    assign o_nxt_data   = (w_p_nxt >= c_p_data_lo) && (w_p_nxt <= c_p_data_hi);
    assign o_nxt_done   = (w_p_nxt == c_p_done);
    assign o_capture    = (w_p == c_p_cap);

endmodule

`default_nettype wire

// File: rtl/bus_sequencer.sv
// ============================================================================
// Module      : bus_sequencer
// Description : Time-multiplexes the system bus between the SPI bridge and
//               the 6502, generates phi2 and times the SRAM strobes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_sequencer
    import bus_timing_pkg::*;
#(
    parameter int SLOT_BITS = c_slot_bits_def
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [16:0] spi_addr,
    input  logic [7:0]  spi_wr_data,
    input  logic        spi_rw_b,
    input  logic        spi_valid,
    output logic        spi_ready,
    output logic        spi_done,
    output logic [7:0]  spi_rd_data,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rw_b,
    output logic        clk_cpu,
    output logic [16:0] bus_addr,
    output logic        bus_rw_b,
    output logic        spi_data_oe,
    input  logic        ram_enable,
    input  logic        write_enable,
    input  logic [7:0]  ram_data_in,
    output logic        ram_oe_b,
    output logic        ram_we_b
);

    slot_e       w_slot;
    slot_e       w_nxt_slot;
    logic        w_nxt_start;
    logic        w_nxt_strobe;
    logic        w_nxt_data;
    logic        w_nxt_done;
    logic        w_capture;

    logic        r_clk_cpu;
    logic [16:0] r_bus_addr;
    logic        r_bus_rw_b;
    logic        r_oe_b;
    logic        r_we_b;
    logic        r_data_oe;
    logic        r_pending;
    logic        r_spi_done;
    logic [7:0]  r_rd_data;
    logic        r_active;
    logic [16:0] r_req_addr;
    logic        r_req_rw_b;

    logic        w_accept;
    logic        w_req_now;
    logic [16:0] w_req_addr;
    logic        w_req_rw_b;
    logic        w_nxt_spi;
    logic        w_cur_spi;
    logic        w_unused;

    phase_counter #(
        .SLOT_BITS (SLOT_BITS)
    ) u_phase_counter (
        .clk          (clk),
        .reset        (reset),
        .o_slot       (w_slot),
        .o_nxt_slot   (w_nxt_slot),
        .o_nxt_start  (w_nxt_start),
        .o_nxt_strobe (w_nxt_strobe),
        .o_nxt_data   (w_nxt_data),
        .o_nxt_done   (w_nxt_done),
        .o_capture    (w_capture)
    );

    // Write data goes straight to the external data-bus mux, gated by spi_data_oe.
    assign w_unused   = ^spi_wr_data;

    assign w_accept   = spi_valid & ~r_pending;
    // A request accepted on the clock that enters an SPI slot still makes that slot.
    assign w_req_now  = r_pending | w_accept;
    assign w_req_addr = r_pending ? r_req_addr : spi_addr;
    assign w_req_rw_b = r_pending ? r_req_rw_b : spi_rw_b;
    assign w_nxt_spi  = (w_nxt_slot == SLOT_SPI);
    assign w_cur_spi  = (w_slot == SLOT_SPI);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_clk_cpu  <= 1'b0;
            r_bus_addr <= '0;
            r_bus_rw_b <= 1'b1;
            r_oe_b     <= 1'b1;
            r_we_b     <= 1'b1;
            r_data_oe  <= 1'b0;
            r_pending  <= 1'b0;
            r_spi_done <= 1'b0;
            r_rd_data  <= '0;
            r_active   <= 1'b0;
            r_req_addr <= '0;
            r_req_rw_b <= 1'b1;
        end else begin
            r_clk_cpu <= (w_nxt_slot == SLOT_CPU);

            if (r_spi_done) begin
                r_pending <= 1'b0;
            end else if (w_accept) begin
                r_pending  <= 1'b1;
                r_req_addr <= spi_addr;
                r_req_rw_b <= spi_rw_b;
            end

            if (w_nxt_start) begin
                if (!w_nxt_spi) begin
                    r_bus_addr <= {1'b0, cpu_addr};
                    r_bus_rw_b <= cpu_rw_b;
                    r_active   <= 1'b1;
                end else if (w_req_now) begin
                    r_bus_addr <= w_req_addr;
                    r_bus_rw_b <= w_req_rw_b;
                    r_active   <= 1'b1;
                end else begin
                    r_active   <= 1'b0;
                end
            end

            // Decoder outputs reflect bus_addr one clock late; the window starts after that.
            r_oe_b     <= ~(w_nxt_strobe & r_active & ram_enable & r_bus_rw_b);
            r_we_b     <= ~(w_nxt_strobe & r_active & ram_enable & write_enable & ~r_bus_rw_b);
            r_data_oe  <= w_nxt_data & r_active & w_nxt_spi & ~r_bus_rw_b;
            r_spi_done <= w_nxt_done & r_active & w_nxt_spi;

            if (w_capture && r_active && w_cur_spi && r_bus_rw_b) begin
                r_rd_data <= ram_data_in;
            end
        end
    end

    assign clk_cpu     = r_clk_cpu;
    assign bus_addr    = r_bus_addr;
    assign bus_rw_b    = r_bus_rw_b;
    assign ram_oe_b    = r_oe_b;
    assign ram_we_b    = r_we_b;
    assign spi_data_oe = r_data_oe;
    assign spi_ready   = ~r_pending;
    assign spi_done    = r_spi_done;
    assign spi_rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: tb/tb_bus_sequencer.sv
// ============================================================================
// Module      : tb_bus_sequencer
// Description : Self-checking bench for bus_sequencer with a scoreboard of
//               expected SPI completions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [16:0] spi_addr = '0;
    logic [7:0]  spi_wr_data = '0;
    logic        spi_rw_b = 1'b1;
    logic        spi_valid = 1'b0;
    logic        spi_ready;
    logic        spi_done;
    logic [7:0]  spi_rd_data;
    logic [15:0] cpu_addr = '0;
    logic        cpu_rw_b = 1'b1;
    logic        clk_cpu;
    logic [16:0] bus_addr;
    logic        bus_rw_b;
    logic        spi_data_oe;
    logic        ram_enable = 1'b0;
    logic        write_enable = 1'b0;
    logic [7:0]  ram_data_in = '0;
    logic        ram_oe_b;
    logic        ram_we_b;

    typedef struct {
        int         done_cyc;
        logic [7:0] rd;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    logic [4:0] tb_cnt = '0;

    bus_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .spi_addr     (spi_addr),
        .spi_wr_data  (spi_wr_data),
        .spi_rw_b     (spi_rw_b),
        .spi_valid    (spi_valid),
        .spi_ready    (spi_ready),
        .spi_done     (spi_done),
        .spi_rd_data  (spi_rd_data),
        .cpu_addr     (cpu_addr),
        .cpu_rw_b     (cpu_rw_b),
        .clk_cpu      (clk_cpu),
        .bus_addr     (bus_addr),
        .bus_rw_b     (bus_rw_b),
        .spi_data_oe  (spi_data_oe),
        .ram_enable   (ram_enable),
        .write_enable (write_enable),
        .ram_data_in  (ram_data_in),
        .ram_oe_b     (ram_oe_b),
        .ram_we_b     (ram_we_b)
    );

    always #5 clk = ~clk;

    // Decoder stand-in: IO at 0x0E000-0x0EFFF, read-only at 0x09000-0x09FFF.
    always @(posedge clk) begin
        ram_enable   <= (bus_addr[16:12] != 5'h0E);
        write_enable <= (bus_addr[16:12] != 5'h09);
    end

    // Reference slot/phase position: {slot, p}.
    always @(posedge clk) begin
        cyc    <= cyc + 1;
        tb_cnt <= reset ? 5'd0 : tb_cnt + 5'd1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_phase(input logic s, input logic [3:0] p);
        for (int i = 0; i < 80; i++) begin
            if (tb_cnt === {s, p}) break;
            tick(1);
        end
        checks++;
        if (tb_cnt !== {s, p}) begin
            failures++;
            $display("FAIL wait_phase got=%0d exp=%0d", tb_cnt, {s, p});
        end
    endtask

    // Completion lands at p=15 of the first SPI slot that begins after acceptance.
    task automatic issue_req(input logic [16:0] a, input logic [7:0] d, input logic rw,
                             input logic [7:0] exp_rd);
        exp_t e;
        e.done_cyc  = cyc + 47 - int'(tb_cnt);
        e.rd        = exp_rd;
        sb.push_back(e);
        spi_addr    = a;
        spi_wr_data = d;
        spi_rw_b    = rw;
        spi_valid   = 1'b1;
        tick(1);
        spi_valid   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        checks++;
        if ({clk_cpu, bus_rw_b, ram_oe_b, ram_we_b, spi_data_oe, spi_ready, spi_done} !== 7'b0111010) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=%b",
                     {clk_cpu, bus_rw_b, ram_oe_b, ram_we_b, spi_data_oe, spi_ready, spi_done}, 7'b0111010);
        end
        checks++;
        if (bus_addr !== 17'h0) begin
            failures++;
            $display("FAIL reset_bus_addr got=%h exp=%h", bus_addr, 17'h0);
        end
        checks++;
        if (spi_rd_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_rd_data got=%h exp=%h", spi_rd_data, 8'h00);
        end
        reset = 1'b0;
    endtask

    task automatic test_free_run();
        int   hi = 0;
        int   rise0 = -1;
        int   rise1 = -1;
        logic prev = 1'b0;
        for (int i = 0; i < 64; i++) begin
            tick(1);
            checks++;
            if (clk_cpu !== tb_cnt[4]) begin
                failures++;
                $display("FAIL free_run_clk_cpu cnt=%0d got=%b exp=%b", tb_cnt, clk_cpu, tb_cnt[4]);
            end
            if (tb_cnt[4] == 1'b0) begin
                checks++;
                if ({ram_oe_b, ram_we_b} !== 2'b11) begin
                    failures++;
                    $display("FAIL free_run_idle_strobes cnt=%0d got=%b exp=11", tb_cnt, {ram_oe_b, ram_we_b});
                end
            end
            if (clk_cpu === 1'b1) hi++;
            if (clk_cpu === 1'b1 && prev === 1'b0) begin
                if (rise0 < 0) rise0 = cyc;
                else if (rise1 < 0) rise1 = cyc;
            end
            prev = clk_cpu;
        end
        checks++;
        if (rise1 - rise0 !== 32 || rise0 < 0) begin
            failures++;
            $display("FAIL free_run_period got=%0d exp=32", rise1 - rise0);
        end
        checks++;
        if (hi !== 32) begin
            failures++;
            $display("FAIL free_run_high_clks got=%0d exp=32", hi);
        end
    endtask

    task automatic test_cpu_read();
        cpu_addr = 16'h8000;
        cpu_rw_b = 1'b1;
        wait_phase(1'b1, 4'd0);
        checks++;
        if ({bus_addr, bus_rw_b} !== {17'h08000, 1'b1}) begin
            failures++;
            $display("FAIL cpu_bus_addr got=%h/%b exp=%h/1", bus_addr, bus_rw_b, 17'h08000);
        end
        for (int p = 1; p < 16; p++) begin
            tick(1);
            checks++;
            if ({ram_oe_b, ram_we_b} !== {!(p >= 2 && p <= 13), 1'b1}) begin
                failures++;
                $display("FAIL cpu_read_strobes p=%0d got=%b exp=%b", p,
                         {ram_oe_b, ram_we_b}, {!(p >= 2 && p <= 13), 1'b1});
            end
        end
    endtask

    task automatic test_spi_write();
        exp_t e;
        wait_phase(1'b1, 4'd4);
        issue_req(17'h00100, 8'hA5, 1'b0, 8'h00);
        checks++;
        if (spi_ready !== 1'b0) begin
            failures++;
            $display("FAIL write_ready_drop got=%b exp=0", spi_ready);
        end
        // A second request while busy must be ignored.
        spi_addr  = 17'h1FFFF;
        spi_rw_b  = 1'b1;
        spi_valid = 1'b1;
        wait_phase(1'b0, 4'd0);
        checks++;
        if ({bus_addr, bus_rw_b} !== {17'h00100, 1'b0}) begin
            failures++;
            $display("FAIL write_bus_addr got=%h/%b exp=%h/0", bus_addr, bus_rw_b, 17'h00100);
        end
        for (int p = 1; p < 16; p++) begin
            tick(1);
            checks++;
            if ({ram_we_b, spi_data_oe, ram_oe_b, spi_done} !==
                {!(p >= 2 && p <= 13), (p >= 1 && p <= 14), 1'b1, (p == 15)}) begin
                failures++;
                $display("FAIL write_strobes p=%0d got=%b exp=%b", p,
                         {ram_we_b, spi_data_oe, ram_oe_b, spi_done},
                         {!(p >= 2 && p <= 13), (p >= 1 && p <= 14), 1'b1, (p == 15)});
            end
        end
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL write_scoreboard got=empty exp=entry");
        end else begin
            e = sb.pop_front();
            if (cyc !== e.done_cyc) begin
                failures++;
                $display("FAIL write_done_time got=%0d exp=%0d", cyc, e.done_cyc);
            end
        end
        spi_valid = 1'b0;
        tick(1);
        checks++;
        if ({spi_ready, spi_done} !== 2'b10) begin
            failures++;
            $display("FAIL write_ready_return got=%b exp=10", {spi_ready, spi_done});
        end
    endtask

    task automatic test_io_read();
        exp_t e;
        ram_data_in = 8'h3C;
        wait_phase(1'b1, 4'd8);
        issue_req(17'h0E810, 8'h00, 1'b1, 8'h3C);
        wait_phase(1'b0, 4'd0);
        for (int p = 1; p < 16; p++) begin
            tick(1);
            checks++;
            if ({ram_oe_b, ram_we_b, spi_done} !== {2'b11, (p == 15)}) begin
                failures++;
                $display("FAIL io_read_strobes p=%0d got=%b exp=%b", p,
                         {ram_oe_b, ram_we_b, spi_done}, {2'b11, (p == 15)});
            end
        end
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL io_read_scoreboard got=empty exp=entry");
        end else begin
            e = sb.pop_front();
            if (spi_rd_data !== e.rd || cyc !== e.done_cyc) begin
                failures++;
                $display("FAIL io_read_data got=%h@%0d exp=%h@%0d", spi_rd_data, cyc, e.rd, e.done_cyc);
            end
        end
    endtask

    task automatic test_capture_point();
        exp_t e;
        ram_data_in = 8'h11;
        wait_phase(1'b1, 4'd6);
        issue_req(17'h00040, 8'h00, 1'b1, 8'h77);
        wait_phase(1'b0, 4'd0);
        for (int p = 1; p < 16; p++) begin
            tick(1);
            if (p == 12) ram_data_in = 8'h77;
            if (p == 13) ram_data_in = 8'hEE;
            checks++;
            if ({ram_oe_b, ram_we_b, spi_done} !== {!(p >= 2 && p <= 13), 1'b1, (p == 15)}) begin
                failures++;
                $display("FAIL ram_read_strobes p=%0d got=%b exp=%b", p,
                         {ram_oe_b, ram_we_b, spi_done}, {!(p >= 2 && p <= 13), 1'b1, (p == 15)});
            end
        end
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL ram_read_scoreboard got=empty exp=entry");
        end else begin
            e = sb.pop_front();
            if (spi_rd_data !== e.rd || cyc !== e.done_cyc) begin
                failures++;
                $display("FAIL ram_read_data got=%h@%0d exp=%h@%0d", spi_rd_data, cyc, e.rd, e.done_cyc);
            end
        end
    endtask

    task automatic test_late_accept();
        exp_t e;
        ram_data_in = 8'h5A;
        wait_phase(1'b0, 4'd0);
        issue_req(17'h00200, 8'h00, 1'b1, 8'h5A);
        for (int i = 0; i < 80; i++) begin
            if (spi_done === 1'b1) break;
            tick(1);
        end
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL late_accept_scoreboard got=empty exp=entry");
        end else begin
            e = sb.pop_front();
            if (cyc !== e.done_cyc || spi_rd_data !== e.rd || tb_cnt !== 5'd15) begin
                failures++;
                $display("FAIL late_accept_done got=%0d/%h/p%0d exp=%0d/%h/p15",
                         cyc, spi_rd_data, tb_cnt, e.done_cyc, e.rd);
            end
        end
        tick(1);
    endtask

    task automatic test_rom_write();
        exp_t e;
        wait_phase(1'b1, 4'd2);
        issue_req(17'h09000, 8'h12, 1'b0, 8'h00);
        wait_phase(1'b0, 4'd0);
        for (int p = 1; p < 16; p++) begin
            tick(1);
            checks++;
            if ({ram_we_b, ram_oe_b, spi_data_oe, spi_done} !== {2'b11, (p <= 14), (p == 15)}) begin
                failures++;
                $display("FAIL rom_write_strobes p=%0d got=%b exp=%b", p,
                         {ram_we_b, ram_oe_b, spi_data_oe, spi_done}, {2'b11, (p <= 14), (p == 15)});
            end
        end
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL rom_write_scoreboard got=empty exp=entry");
        end else begin
            e = sb.pop_front();
            if (cyc !== e.done_cyc) begin
                failures++;
                $display("FAIL rom_write_done_time got=%0d exp=%0d", cyc, e.done_cyc);
            end
        end
        tick(1);
    endtask

    task automatic test_reset_mid();
        int   done_seen = 0;
        logic cpu_at15 = 1'b1;
        logic cpu_at16 = 1'b0;
        wait_phase(1'b1, 4'd4);
        issue_req(17'h00100, 8'hC3, 1'b0, 8'h00);
        wait_phase(1'b0, 4'd6);
        checks++;
        if (ram_we_b !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_active got=%b exp=0", ram_we_b);
        end
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        sb.delete();
        checks++;
        if ({ram_we_b, ram_oe_b, spi_data_oe, spi_ready, spi_done, clk_cpu} !== 6'b110100) begin
            failures++;
            $display("FAIL reset_mid_outputs got=%b exp=110100",
                     {ram_we_b, ram_oe_b, spi_data_oe, spi_ready, spi_done, clk_cpu});
        end
        for (int i = 1; i <= 48; i++) begin
            tick(1);
            if (spi_done === 1'b1) done_seen++;
            if (i == 15) cpu_at15 = clk_cpu;
            if (i == 16) cpu_at16 = clk_cpu;
        end
        checks++;
        if (done_seen !== 0) begin
            failures++;
            $display("FAIL reset_mid_no_done got=%0d exp=0", done_seen);
        end
        checks++;
        if ({cpu_at15, cpu_at16} !== 2'b01) begin
            failures++;
            $display("FAIL reset_mid_restart got=%b exp=01", {cpu_at15, cpu_at16});
        end
    endtask

    initial begin
        tick(1);
        test_reset();
        test_free_run();
        test_cpu_read();
        test_spi_write();
        test_io_read();
        test_capture_point();
        test_late_accept();
        test_rom_write();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire
